// File: rtl/core_control_unit.sv
// Multi-cycle fetch/decode/execute sequencer for the 8-bit ProtoCore datapath.
// Owns the PC, instruction register, latched ALU flags and the data-RAM handshake.
module core_control_unit #(
    parameter int PC_WIDTH    = 8,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                clk,
    input  logic                rst,
    output logic [PC_WIDTH-1:0] imem_addr,
    input  logic [15:0]         imem_data,
    output logic                mem_req,
    output logic                mem_we,
    output logic [7:0]          mem_addr,
    output logic [7:0]          mem_wdata,
    input  logic                mem_ready,
    input  logic [7:0]          read_a,
    input  logic [7:0]          read_b,
    input  logic                alu_zero,
    input  logic                alu_carry,
    output logic                write_alu,
    output logic                write_en,
    output logic                is_load,
    output logic                alu_imm_flag,
    output logic [2:0]          alu_opcode,
    output logic [3:0]          write_addr,
    output logic [3:0]          ra_addr,
    output logic [3:0]          rb_addr,
    output logic [7:0]          imm_data,
    output logic                zero_flag,
    output logic                carry_flag,
    output logic                halted,
    output logic                mem_error
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_HALT   = 3'd4
    } state_t;

    localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;

    state_t              state_q, state_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [15:0]         ir_q, ir_d;
    logic                zero_q, zero_d;
    logic                carry_q, carry_d;
    logic                mem_error_q, mem_error_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;

    logic [3:0]          op;
    logic                is_alu_op, is_addi, is_ldi, is_ld, is_st;
    logic                is_jmp, is_bz, is_bc, is_halt;
    logic                branch_taken;
    logic                timeout_hit;
    logic [PC_WIDTH-1:0] pc_inc;
    logic [PC_WIDTH-1:0] branch_target;

    assign op        = ir_q[15:12];
    assign is_alu_op = (op[3] == 1'b0);
    assign is_addi   = (op == 4'h8);
    assign is_ldi    = (op == 4'h9);
    assign is_ld     = (op == 4'hA);
    assign is_st     = (op == 4'hB);
    assign is_jmp    = (op == 4'hC);
    assign is_bz     = (op == 4'hD);
    assign is_bc     = (op == 4'hE);
    assign is_halt   = (op == 4'hF);

    assign branch_taken  = is_jmp | (is_bz & zero_q) | (is_bc & carry_q);
    assign pc_inc        = pc_q + 1'b1;
    assign branch_target = PC_WIDTH'(ir_q[7:0]);

    // A timeout of zero means the core waits on the RAM forever.
    generate
        if (MEM_TIMEOUT == 0) begin : g_no_timeout
            assign timeout_hit = 1'b0;
        end else begin : g_timeout
            assign timeout_hit = (wait_q == WAIT_W'(MEM_TIMEOUT - 1));
        end
    endgenerate

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ir_d        = ir_q;
        zero_d      = zero_q;
        carry_d     = carry_q;
        mem_error_d = mem_error_q;
        wait_d      = wait_q;
        write_en    = 1'b0;
        write_alu   = 1'b0;
        is_load     = 1'b0;
        mem_req     = 1'b0;
        mem_we      = 1'b0;

        case (state_q)
            S_FETCH: begin
                state_d = S_DECODE;
            end
            S_DECODE: begin
                ir_d    = imem_data;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                wait_d = '0;
                if (is_alu_op || is_addi || is_ldi) begin
                    write_en  = 1'b1;
                    write_alu = ~is_ldi;
                    pc_d      = pc_inc;
                    state_d   = S_FETCH;
                    if (!is_ldi) begin
                        zero_d  = alu_zero;
                        carry_d = alu_carry;
                    end
                end else if (is_ld || is_st) begin
                    state_d = S_MEM;
                end else if (is_halt) begin
                    state_d = S_HALT;
                end else begin
                    pc_d    = branch_taken ? branch_target : pc_inc;
                    state_d = S_FETCH;
                end
            end
            S_MEM: begin
                mem_req = 1'b1;
                mem_we  = is_st;
                if (mem_ready) begin
                    // Load data is on ram_data this very cycle, so the write fires now.
                    write_en = is_ld;
                    is_load  = is_ld;
                    pc_d     = pc_inc;
                    wait_d   = '0;
                    state_d  = S_FETCH;
                end else if (timeout_hit) begin
                    mem_error_d = 1'b1;
                    state_d     = S_HALT;
                end else if (MEM_TIMEOUT != 0) begin
                    wait_d = wait_q + 1'b1;
                end
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_FETCH;
            pc_q        <= '0;
            ir_q        <= '0;
            zero_q      <= 1'b0;
            carry_q     <= 1'b0;
            mem_error_q <= 1'b0;
            wait_q      <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ir_q        <= ir_d;
            zero_q      <= zero_d;
            carry_q     <= carry_d;
            mem_error_q <= mem_error_d;
            wait_q      <= wait_d;
        end
    end

    // ADDI reads its own destination as the A operand.
    assign ra_addr      = is_addi ? ir_q[11:8] : ir_q[7:4];
    assign rb_addr      = ir_q[3:0];
    assign write_addr   = ir_q[11:8];
    assign imm_data     = ir_q[7:0];
    assign alu_opcode   = ir_q[14:12];
    assign alu_imm_flag = is_addi;

    assign imem_addr  = pc_q;
    assign mem_addr   = read_a;
    assign mem_wdata  = read_b;
    assign zero_flag  = zero_q;
    assign carry_flag = carry_q;
    assign halted     = (state_q == S_HALT);
    assign mem_error  = mem_error_q;

endmodule

// File: tb/tb_core_control_unit.sv
// Directed bench for core_control_unit: ROM, RAM and register-file/ALU models around the
// sequencer, with expected register writes and RAM transactions queued ahead of the DUT.
module tb_core_control_unit;

    localparam int PC_WIDTH    = 8;
    localparam int MEM_TIMEOUT = 15;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [PC_WIDTH-1:0] imem_addr;
    logic [15:0]         imem_data;
    logic                mem_req, mem_we, mem_ready;
    logic [7:0]          mem_addr, mem_wdata;
    logic [7:0]          read_a, read_b;
    logic                alu_zero, alu_carry;
    logic                write_alu, write_en, is_load, alu_imm_flag;
    logic [2:0]          alu_opcode;
    logic [3:0]          write_addr, ra_addr, rb_addr;
    logic [7:0]          imm_data;
    logic                zero_flag, carry_flag, halted, mem_error;

    always #5 clk = ~clk;

    core_control_unit #(.PC_WIDTH(PC_WIDTH), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .imem_addr(imem_addr), .imem_data(imem_data),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready),
        .read_a(read_a), .read_b(read_b), .alu_zero(alu_zero), .alu_carry(alu_carry),
        .write_alu(write_alu), .write_en(write_en), .is_load(is_load),
        .alu_imm_flag(alu_imm_flag), .alu_opcode(alu_opcode),
        .write_addr(write_addr), .ra_addr(ra_addr), .rb_addr(rb_addr), .imm_data(imm_data),
        .zero_flag(zero_flag), .carry_flag(carry_flag), .halted(halted), .mem_error(mem_error)
    );

    // Environment: ROM, RAM and datapath
    logic [15:0] rom  [256];
    logic [7:0]  ram  [256];
    logic [7:0]  regs [16];
    logic        clear_regs = 1'b0;
    logic        ram_dead = 1'b0;
    logic        force_ready = 1'b0;
    int unsigned wait_states = 0;
    int unsigned req_cnt = 0;
    logic [7:0]  ram_data;
    logic [7:0]  alu_b;
    logic [8:0]  alu9;

    always @(posedge clk) imem_data <= rom[imem_addr];

    assign read_a    = regs[ra_addr];
    assign read_b    = regs[rb_addr];
    assign ram_data  = ram[mem_addr];
    assign mem_ready = force_ready || (mem_req && !ram_dead && (req_cnt == wait_states));

    always_comb begin
        alu_b = alu_imm_flag ? imm_data : read_b;
        alu9  = 9'h000;
        case (alu_opcode)
            3'd0: alu9 = {1'b0, read_a} + {1'b0, alu_b};
            3'd1: alu9 = {1'b0, read_a} - {1'b0, alu_b};
            3'd2: alu9 = {1'b0, read_a & alu_b};
            3'd3: alu9 = {1'b0, read_a | alu_b};
            3'd4: alu9 = {1'b0, read_a ^ alu_b};
            3'd5: alu9 = {1'b0, ~read_a};
            3'd6: alu9 = {read_a, 1'b0};
            default: alu9 = {read_a[0], 1'b0, read_a[7:1]};
        endcase
    end
    assign alu_zero  = (alu9[7:0] == 8'h00);
    assign alu_carry = alu9[8];

    always @(posedge clk) begin
        if (mem_req && !mem_ready) req_cnt <= req_cnt + 1;
        else                       req_cnt <= 0;
        if (clear_regs) begin
            for (int i = 0; i < 16; i++)  regs[i] <= 8'h00;
            for (int i = 0; i < 256; i++) ram[i]  <= 8'h00;
        end else begin
            if (write_en && write_addr != 4'd0)
                regs[write_addr] <= is_load ? ram_data : (write_alu ? alu9[7:0] : imm_data);
            if (mem_req && mem_ready && mem_we)
                ram[mem_addr] <= mem_wdata;
        end
    end

    // Scoreboard and checking
    int n_pass  = 0;
    int n_total = 0;
    logic [13:0] wq [$];   // {valid, addr, data, is_load}
    logic [25:0] mq [$];   // {valid, we, addr, wdata, req_cycles}
    logic [7:0]  fq [$];   // expected fetch addresses, three cycles apart

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic exp_wr(input logic [3:0] a, input logic [7:0] d, input logic l);
        wq.push_back({1'b1, a, d, l});
    endtask

    int unsigned req_cycles  = 0;
    int unsigned load_pulses = 0;
    logic [13:0] w_exp;
    logic [25:0] m_exp;
    logic [7:0]  w_data_obs;

    always @(posedge clk) begin
        #1;
        if (write_en) begin
            w_exp = 14'h0000;
            if (wq.size() > 0) w_exp = wq.pop_front();
            w_data_obs = is_load ? ram_data : (write_alu ? alu9[7:0] : imm_data);
            chk("reg_write", {18'h0, 1'b1, write_addr, w_data_obs, is_load}, {18'h0, w_exp});
            $display("write r%0d <= 0x%02h load=%0d", write_addr, w_data_obs, is_load);
            if (is_load) load_pulses++;
        end
        if (mem_req) begin
            req_cycles++;
            if (mem_ready) begin
                m_exp = 26'h0;
                if (mq.size() > 0) m_exp = mq.pop_front();
                chk("mem_xfer", {6'h0, 1'b1, mem_we, mem_addr, (mem_we ? mem_wdata : 8'h00),
                                 req_cycles[7:0]}, {6'h0, m_exp});
                $display("mem we=%0d addr=0x%02h wdata=0x%02h cycles=%0d",
                         mem_we, mem_addr, mem_wdata, req_cycles);
                req_cycles = 0;
            end
        end else begin
            req_cycles = 0;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic load_rom_halts();
        for (int i = 0; i < 256; i++) rom[i] = 16'hF000;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_regs = 1'b1;
        wq.delete();
        mq.delete();
        load_pulses = 0;
        step(2);
        rst = 1'b0;
        clear_regs = 1'b0;
    endtask

    task automatic run_fetches(input string tag);
        logic [7:0] e;
        while (fq.size() > 0) begin
            e = fq.pop_front();
            chk(tag, imem_addr, e);
            $display("fetch 0x%02h", imem_addr);
            if (fq.size() > 0) step(3);
        end
    endtask

    task automatic drain(input string tag);
        #2;
        chk({tag, "_writes_left"}, wq.size(), 0);
        chk({tag, "_mem_left"}, mq.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int unsigned req_seen;

    initial begin
        // Straight-line ALU/LDI/ADDI program, then HALT
        load_rom_halts();
        rom[0] = 16'h9105; rom[1] = 16'h92FB; rom[2] = 16'h0312; rom[3] = 16'h8305;
        do_reset();
        chk("rst_imem_addr", imem_addr, 8'h00);
        chk("rst_mem_req", mem_req, 1'b0);
        chk("rst_write_en", write_en, 1'b0);
        chk("rst_write_alu", write_alu, 1'b0);
        chk("rst_is_load", is_load, 1'b0);
        chk("rst_halted", halted, 1'b0);
        chk("rst_mem_error", mem_error, 1'b0);
        chk("rst_flags", {zero_flag, carry_flag}, 2'b00);
        exp_wr(4'd1, 8'h05, 1'b0);
        exp_wr(4'd2, 8'hFB, 1'b0);
        exp_wr(4'd3, 8'h00, 1'b0);
        exp_wr(4'd3, 8'h05, 1'b0);
        step(8);
        chk("add_exec_write_en", write_en, 1'b1);
        chk("add_exec_write_alu", write_alu, 1'b1);
        chk("add_exec_waddr", write_addr, 4'd3);
        chk("add_exec_ports", {ra_addr, rb_addr}, 8'h12);
        step(1);
        chk("add_flags", {zero_flag, carry_flag}, 2'b11);
        chk("add_next_pc", imem_addr, 8'h03);
        chk("fetch_no_write", write_en, 1'b0);
        step(2);
        chk("addi_imm_flag", alu_imm_flag, 1'b1);
        chk("addi_ra_is_rd", ra_addr, 4'd3);
        chk("addi_imm", imm_data, 8'h05);
        step(1);
        chk("addi_flags", {zero_flag, carry_flag}, 2'b00);
        step(3);
        for (int i = 0; i < 20; i++) begin
            chk("halt_hold", {halted, write_en, mem_req, imem_addr}, {1'b1, 1'b0, 1'b0, 8'h04});
            step(1);
        end
        drain("alu");

        // Store then load, two RAM wait states each
        load_rom_halts();
        rom[0] = 16'h9105; rom[1] = 16'h92FB; rom[2] = 16'hB012; rom[3] = 16'hA410;
        wait_states = 2;
        do_reset();
        exp_wr(4'd1, 8'h05, 1'b0);
        exp_wr(4'd2, 8'hFB, 1'b0);
        exp_wr(4'd4, 8'hFB, 1'b1);
        mq.push_back({1'b1, 1'b1, 8'h05, 8'hFB, 8'd3});
        mq.push_back({1'b1, 1'b0, 8'h05, 8'h00, 8'd3});
        step(9);
        chk("st_mem_req", {mem_req, mem_we}, 2'b11);
        chk("st_addr_data", {mem_addr, mem_wdata}, 16'h05FB);
        chk("st_no_write", write_en, 1'b0);
        step(6);
        chk("ld_mem_req", {mem_req, mem_we}, 2'b10);
        step(3);
        chk("ldst_pc", imem_addr, 8'h04);
        step(3);
        chk("ldst_halted", halted, 1'b1);
        chk("ld_pulse_once", load_pulses, 1);
        chk("ram5_stored", ram[5], 8'hFB);
        drain("mem");

        // Branches: BZ taken on prior ALU flag, BZ/BC untaken, JMP
        load_rom_halts();
        rom[0] = 16'h9105; rom[1] = 16'h92FB; rom[2] = 16'h0312; rom[3] = 16'h9101;
        rom[4] = 16'hD010; rom[8'h10] = 16'h0112; rom[8'h11] = 16'hD020;
        rom[8'h12] = 16'hE030; rom[8'h13] = 16'hC040;
        wait_states = 0;
        do_reset();
        exp_wr(4'd1, 8'h05, 1'b0);
        exp_wr(4'd2, 8'hFB, 1'b0);
        exp_wr(4'd3, 8'h00, 1'b0);
        exp_wr(4'd1, 8'h01, 1'b0);
        exp_wr(4'd1, 8'hFC, 1'b0);
        fq = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h10, 8'h11, 8'h12, 8'h13, 8'h40};
        run_fetches("branch_fetch");
        step(3);
        chk("branch_halted", halted, 1'b1);
        chk("branch_flags", {zero_flag, carry_flag}, 2'b00);
        drain("branch");

        // PC wrap from 0xFF to 0x00
        load_rom_halts();
        rom[0] = 16'hC0FF; rom[8'hFF] = 16'h9107;
        do_reset();
        exp_wr(4'd1, 8'h07, 1'b0);
        fq = '{8'h00, 8'hFF, 8'h00, 8'hFF};
        run_fetches("wrap_fetch");
        drain("wrap");

        // JMP 0x00 loop for four iterations
        load_rom_halts();
        rom[0] = 16'h9101; rom[1] = 16'h9202; rom[2] = 16'hC000;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            exp_wr(4'd1, 8'h01, 1'b0);
            exp_wr(4'd2, 8'h02, 1'b0);
            fq.push_back(8'h00);
            fq.push_back(8'h01);
            fq.push_back(8'h02);
        end
        fq.push_back(8'h00);
        run_fetches("loop_fetch");
        drain("loop");

        // RAM never answers: timeout after fifteen MEM cycles
        load_rom_halts();
        rom[0] = 16'hA410;
        ram_dead = 1'b1;
        do_reset();
        step(3);
        req_seen = 0;
        for (int i = 0; i < 15; i++) begin
            if (mem_req) req_seen++;
            step(1);
        end
        chk("timeout_req_cycles", req_seen, 15);
        chk("timeout_halted", halted, 1'b1);
        chk("timeout_mem_error", mem_error, 1'b1);
        chk("timeout_req_low", {mem_req, write_en}, 2'b00);
        step(5);
        chk("timeout_hold", {halted, mem_error, mem_req}, 3'b110);
        drain("timeout");

        // Reset in the middle of a MEM wait
        load_rom_halts();
        rom[0] = 16'h9105; rom[1] = 16'h92FB; rom[2] = 16'h0312; rom[3] = 16'hA410;
        do_reset();
        exp_wr(4'd1, 8'h05, 1'b0);
        exp_wr(4'd2, 8'hFB, 1'b0);
        exp_wr(4'd3, 8'h00, 1'b0);
        step(13);
        chk("midmem_req", mem_req, 1'b1);
        chk("midmem_flags", {zero_flag, carry_flag}, 2'b11);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        chk("midrst_req", mem_req, 1'b0);
        chk("midrst_pc", imem_addr, 8'h00);
        chk("midrst_flags", {zero_flag, carry_flag}, 2'b00);
        chk("midrst_status", {halted, mem_error, write_en}, 3'b000);
        force_ready = 1'b1;
        exp_wr(4'd1, 8'h05, 1'b0);
        fq = '{8'h00, 8'h01};
        run_fetches("restart_fetch");
        force_ready = 1'b0;
        drain("restart");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
